// File: rtl/smg_disp_arbiter.sv
// Round-robin owner of the shared 4-digit display, with a blanking gap between owners.
// Grant 1 clock after req; data/unblank 1 clock after grant; no backpressure, req is level-held.
module smg_disp_arbiter #(
   parameter int CLK_IN      = 20_000_000,
   parameter int TICK_HZ     = 1_000,
   parameter int DWELL_TICKS = 2000,
   parameter int BLANK_TICKS = 50
) (
   input  logic        clk,
   input  logic        res_n,
   input  logic [3:0]  req,
   input  logic [63:0] src_data,
   input  logic        hold,
   output logic [3:0]  grant,
   output logic [1:0]  disp_src,
   output logic [15:0] disp_data,
   output logic        disp_blank,
   output logic        tick
);

   localparam int TICK_DIV   = (CLK_IN / TICK_HZ < 1) ? 1 : CLK_IN / TICK_HZ;
   localparam int TW         = $clog2(TICK_DIV + 1);
   localparam int CNT_MAX    = (DWELL_TICKS > BLANK_TICKS) ? DWELL_TICKS : BLANK_TICKS;
   localparam int CW         = $clog2(CNT_MAX + 1);
   localparam int BLANK_LAST = (BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0;

   typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

   state_t      state, state_nxt;
   logic [TW-1:0] tick_cnt, tick_cnt_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [1:0]  ptr, ptr_nxt, win, rr_idx, src_nxt;
   logic        win_vld, blank_nxt, gap_done;
   logic [3:0]  grant_nxt, others;
   logic [15:0] owner_val, clamped, data_nxt;

   assign tick_cnt_nxt = (tick_cnt == TW'(TICK_DIV - 1)) ? '0 : tick_cnt + TW'(1);

   // Registered so tick stays low in reset even when the divider is 1.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         tick_cnt <= '0;
         tick     <= 1'b0;
      end else begin
         tick_cnt <= tick_cnt_nxt;
         tick     <= (tick_cnt_nxt == TW'(TICK_DIV - 1));
      end
   end

   // Nearest requester after ptr wins; ptr itself has lowest priority.
   always_comb begin
      win     = ptr;
      win_vld = 1'b0;
      rr_idx  = ptr;
      for (int k = 4; k >= 1; k--) begin
         rr_idx = ptr + 2'(k);
         if (req[rr_idx]) begin
            win     = rr_idx;
            win_vld = 1'b1;
         end
      end
   end

   assign owner_val = src_data[{disp_src, 4'b0000} +: 16];
   assign clamped   = (owner_val > 16'd9999) ? 16'd9999 : owner_val;
   assign others    = req & ~(4'b0001 << disp_src);
   assign gap_done  = (BLANK_TICKS == 0) || (tick && (cnt == CW'(BLANK_LAST)));

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ptr_nxt   = ptr;
      grant_nxt = grant;
      src_nxt   = disp_src;
      data_nxt  = disp_data;
      blank_nxt = disp_blank;
      case (state)
         IDLE: begin
            grant_nxt = 4'b0000;
            blank_nxt = 1'b1;
            if (win_vld) begin
               state_nxt = SHOW;
               grant_nxt = 4'b0001 << win;
               src_nxt   = win;
               ptr_nxt   = win;
               cnt_nxt   = '0;
            end
         end
         SHOW: begin
            data_nxt  = clamped;
            blank_nxt = 1'b0;
            if (!req[disp_src]) begin
               state_nxt = GAP;
               grant_nxt = 4'b0000;
               blank_nxt = 1'b1;
               cnt_nxt   = '0;
            end else if (tick) begin
               if (cnt == CW'(DWELL_TICKS - 1)) begin
                  cnt_nxt = '0;
                  if (!hold && (others != 4'b0000)) begin
                     state_nxt = GAP;
                     grant_nxt = 4'b0000;
                     blank_nxt = 1'b1;
                  end
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
         end
         GAP: begin
            grant_nxt = 4'b0000;
            blank_nxt = 1'b1;
            if (gap_done) begin
               cnt_nxt = '0;
               if (win_vld) begin
                  state_nxt = SHOW;
                  grant_nxt = 4'b0001 << win;
                  src_nxt   = win;
                  ptr_nxt   = win;
               end else begin
                  state_nxt = IDLE;
               end
            end else if (tick) begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = 4'b0000;
            blank_nxt = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state      <= IDLE;
         cnt        <= '0;
         ptr        <= 2'd3;
         grant      <= 4'b0000;
         disp_src   <= 2'd0;
         disp_data  <= 16'd0;
         disp_blank <= 1'b1;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         ptr        <= ptr_nxt;
         grant      <= grant_nxt;
         disp_src   <= src_nxt;
         disp_data  <= data_nxt;
         disp_blank <= blank_nxt;
      end
   end

endmodule

// File: tb/tb_smg_disp_arbiter.sv
// Directed bench for smg_disp_arbiter: expected display transitions are queued with the stimulus
// and popped by a monitor whenever the visible output tuple changes.
module tb_smg_disp_arbiter;

   logic        clk = 1'b0;
   logic        res_n = 1'b0;
   logic [3:0]  req = 4'b0000;
   logic [63:0] src_data = '0;
   logic        hold = 1'b0;
   logic [3:0]  grant;
   logic [1:0]  disp_src;
   logic [15:0] disp_data;
   logic        disp_blank;
   logic        tick;

   typedef struct packed {
      logic [3:0]  g;
      logic [1:0]  s;
      logic [15:0] d;
      logic        b;
   } ev_t;

   ev_t exp_q[$];
   ev_t prev, cur;
   bit  mon_en = 1'b0;
   int  n_chk = 0;
   int  n_pass = 0;

   always #5 clk = ~clk;

   smg_disp_arbiter #(
      .CLK_IN(20), .TICK_HZ(1), .DWELL_TICKS(3), .BLANK_TICKS(1)
   ) dut (
      .clk(clk), .res_n(res_n), .req(req), .src_data(src_data), .hold(hold),
      .grant(grant), .disp_src(disp_src), .disp_data(disp_data),
      .disp_blank(disp_blank), .tick(tick)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
   endtask

   task automatic push(input logic [3:0] g, input logic [1:0] s, input logic [15:0] d, input logic b);
      ev_t e;
      e.g = g; e.s = s; e.d = d; e.b = b;
      exp_q.push_back(e);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_grant(input logic [3:0] g, input int budget, input string tag);
      int k = 0;
      while (grant !== g && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(grant), 32'(g));
   endtask

   task automatic wait_tick(input int budget, input string tag);
      int k = 0;
      while (tick !== 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(tick), 32'd1);
   endtask

   // Every change of the visible tuple must match the next queued expectation.
   always @(negedge clk) begin
      if (mon_en) begin
         cur = {grant, disp_src, disp_data, disp_blank};
         if (cur !== prev) begin
            if (exp_q.size() == 0) chk("unexpected_change", 32'(cur), 32'(prev));
            else chk("display_event", 32'(cur), 32'(exp_q.pop_front()));
            prev = cur;
         end
      end
   end

   initial begin
      int k, n, m;
      // 1: reset values, then idle tick cadence
      #12;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_blank", 32'(disp_blank), 32'd1);
      chk("rst_data", 32'(disp_data), 32'd0);
      chk("rst_src", 32'(disp_src), 32'd0);
      chk("rst_tick", 32'(tick), 32'd0);
      @(negedge clk);
      res_n = 1'b1;
      prev = {grant, disp_src, disp_data, disp_blank};
      mon_en = 1'b1;
      k = 0;
      while (tick !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("first_tick", 32'(k), 32'd19);
      @(negedge clk);
      chk("tick_width", 32'(tick), 32'd0);
      k = 1;
      while (tick !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("tick_period", 32'(k), 32'd20);
      chk("idle_grant", 32'(grant), 32'd0);

      // 2: single requester keeps the display indefinitely
      src_data[15:0] = 16'd1234;
      req = 4'b0001;
      push(4'b0001, 2'd0, 16'd0, 1'b1);
      push(4'b0001, 2'd0, 16'd1234, 1'b0);
      @(negedge clk);
      chk("t2_grant_latency", 32'(grant), 32'h1);
      chk("t2_blank_first", 32'(disp_blank), 32'd1);
      @(negedge clk);
      chk("t2_data", 32'(disp_data), 32'd1234);
      chk("t2_unblank", 32'(disp_blank), 32'd0);
      cyc(150);
      chk("t2_retained", 32'(grant), 32'h1);
      chk("t2_events_done", 32'(exp_q.size()), 32'd0);

      // 3: rotation between sources 0 and 2
      src_data[15:0]  = 16'd11;
      src_data[47:32] = 16'd22;
      req = 4'b0101;
      push(4'b0001, 2'd0, 16'd11, 1'b0);
      push(4'b0000, 2'd0, 16'd11, 1'b1);
      push(4'b0100, 2'd2, 16'd11, 1'b1);
      push(4'b0100, 2'd2, 16'd22, 1'b0);
      push(4'b0000, 2'd2, 16'd22, 1'b1);
      push(4'b0001, 2'd0, 16'd22, 1'b1);
      push(4'b0001, 2'd0, 16'd11, 1'b0);
      wait_grant(4'b0100, 200, "t3_src2_granted");
      n = 0; m = 0;
      while (grant === 4'b0100 && m < 200) begin
         if (tick) n++;
         @(negedge clk);
         m++;
      end
      chk("t3_dwell_ticks", 32'(n), 32'd3);
      n = 0;
      while (grant === 4'b0000 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("t3_gap_cycles", 32'(n), 32'd20);
      chk("t3_back_to_src0", 32'(grant), 32'h1);
      cyc(2);

      // 4: clamp on source 1, then owner drop mid-dwell
      src_data[31:16] = 16'd12345;
      req = 4'b0010;
      push(4'b0000, 2'd0, 16'd11, 1'b1);
      push(4'b0010, 2'd1, 16'd11, 1'b1);
      push(4'b0010, 2'd1, 16'd9999, 1'b0);
      wait_grant(4'b0010, 60, "t4_src1_granted");
      @(negedge clk);
      chk("t4_clamp", 32'(disp_data), 32'd9999);
      wait_tick(30, "t4_tick_mid_dwell");
      cyc(5);
      req = 4'b0000;
      push(4'b0000, 2'd1, 16'd9999, 1'b1);
      @(negedge clk);
      chk("t4_drop_grant", 32'(grant), 32'd0);
      chk("t4_drop_blank", 32'(disp_blank), 32'd1);
      wait_tick(30, "t4_gap_tick");
      @(negedge clk);

      // 5: hold, rotation to ptr+1, and requests changing during the gap
      hold = 1'b1;
      req = 4'b1111;
      src_data[63:48] = 16'd4321;
      push(4'b0100, 2'd2, 16'd9999, 1'b1);
      push(4'b0100, 2'd2, 16'd22, 1'b0);
      @(negedge clk);
      chk("t5_idle_latency", 32'(grant), 32'h4);
      cyc(120);
      chk("t5_hold_keeps", 32'(grant), 32'h4);
      hold = 1'b0;
      push(4'b0000, 2'd2, 16'd22, 1'b1);
      push(4'b1000, 2'd3, 16'd22, 1'b1);
      push(4'b1000, 2'd3, 16'd4321, 1'b0);
      push(4'b0000, 2'd3, 16'd4321, 1'b1);
      wait_grant(4'b1000, 120, "t5_rotate_src3");
      wait_grant(4'b0000, 80, "t5_gap_entry");
      req = 4'b0000;
      cyc(5);
      req = 4'b0100;
      cyc(5);
      req = 4'b0010;
      push(4'b0010, 2'd1, 16'd4321, 1'b1);
      push(4'b0010, 2'd1, 16'd9999, 1'b0);
      wait_grant(4'b0010, 40, "t5_gap_exit_winner");
      cyc(3);

      // 6: asynchronous reset between edges, then fresh arbitration
      @(posedge clk);
      #2;
      res_n = 1'b0;
      push(4'b0000, 2'd0, 16'd0, 1'b1);
      #1;
      chk("t6_async_grant", 32'(grant), 32'd0);
      chk("t6_async_blank", 32'(disp_blank), 32'd1);
      chk("t6_async_data", 32'(disp_data), 32'd0);
      req = 4'b1010;
      @(negedge clk);
      @(negedge clk);
      res_n = 1'b1;
      push(4'b0010, 2'd1, 16'd0, 1'b1);
      push(4'b0010, 2'd1, 16'd9999, 1'b0);
      @(negedge clk);
      chk("t6_first_grant", 32'(grant), 32'h2);
      cyc(2);
      req = 4'b0000;
      push(4'b0000, 2'd1, 16'd9999, 1'b1);
      cyc(50);
      chk("all_events_seen", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
